paralelo_serie_param: RTL
=========================

# paralelo_serie_param

Parametrised parallel-to-serial converter for the PHY transmit path. It accepts parallel words through a valid/ready handshake, buffers one word, and shifts words out one bit per `clk_8f` cycle. When no data is pending it inserts a configurable idle word (default 0xBC). It generalises the fixed 8-bit serializer with programmable width, selectable bit order, flow control, and word-boundary/data-valid flags for the downstream lane.

## Interface
- `WIDTH`, 8, word width in bits (≥2).
- `IDLE_WORD`, `8'hBC` (WIDTH bits), word transmitted when no data is available.
- `MSB_FIRST`, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- `clk_8f`  in  1  bit clock, the only clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  WIDTH  parallel word.
- `valid_in`  in  1  `data_in` is valid.
- `ready_out`  out  1  block can accept `data_in` this cycle.
- `data_out`  out  1  serial bit.
- `valid_out`  out  1  current word on `data_out` is data (1) or idle (0).
- `word_start`  out  1  `data_out` carries the first bit of a word.
- `data2send`  out  WIDTH  word currently being serialised.

## Operation
- State registers:
  - `bit_cnt` (clog2(WIDTH) bits, counts 0..WIDTH-1)
  - `shreg` (WIDTH)
  - `word_is_data` (1)
  - `hold` (WIDTH)
  - `hold_full` (1)
- Outputs are combinational from the state registers:
  - `data2send` = `shreg`
  - `data_out` = `shreg[WIDTH-1-bit_cnt]` when MSB_FIRST, else `shreg[bit_cnt]`
  - `word_start` = (`bit_cnt` == 0)
  - `valid_out` = `word_is_data`
- `boundary` = (`bit_cnt` == WIDTH-1).
- `ready_out` = !`hold_full` || `boundary`.
- Handshake: a transfer occurs when `valid_in` && `ready_out`. While `ready_out` is 0, the source holds `data_in` and `valid_in` stable.
- `bit_cnt` increments every cycle and wraps from WIDTH-1 to 0.
- At `boundary`, next-word selection in priority order:
  1. `hold_full`: `shreg` ← `hold`, `word_is_data` ← 1. A simultaneous transfer writes `data_in` into `hold`, so `hold_full` stays 1; otherwise `hold_full` ← 0.
  2. !`hold_full` and transfer: `shreg` ← `data_in` (bypass), `word_is_data` ← 1, `hold_full` stays 0.
  3. Otherwise: `shreg` ← IDLE_WORD, `word_is_data` ← 0.
- Not at `boundary`: a transfer writes `hold` ← `data_in` and sets `hold_full` ← 1. `shreg` is unchanged.
- No overflow is possible: `ready_out` prevents a write while `hold` is full mid-word.
- Data words are never split or dropped except by reset.

## Timing
- Reset (registered at the rising edge with `reset`=1):
  - `bit_cnt`=0, `shreg`=IDLE_WORD, `word_is_data`=0, `hold_full`=0, `hold`=0.
  - Resulting outputs: `data2send`=IDLE_WORD, `valid_out`=0, `word_start`=1, `ready_out`=1, `data_out`=first bit of IDLE_WORD (1 for 0xBC, MSB first).
- The first word after reset is always idle.
- Reset mid-word discards the word in flight and any held word. Serialisation restarts at bit 0 of IDLE_WORD on the next cycle.
- Word period is exactly WIDTH cycles. `word_start` pulses for 1 cycle every WIDTH cycles.
- Latency:
  - Word accepted at `boundary`: first bit appears the next cycle.
  - Word accepted mid-word: first bit appears the cycle after the next `boundary`, i.e. ≤ WIDTH cycles.
- Sustained throughput is one word per WIDTH cycles with no idle gaps. At that rate `ready_out` is high only on `boundary` once `hold` is full.
- `valid_out` and `data2send` change only on the cycle `word_start` rises.

## Test plan
- Idle after reset, WIDTH=8, MSB_FIRST=1, `valid_in`=0 → `data_out` repeats 1,0,1,1,1,1,0,0; `valid_out`=0; `word_start` every 8 cycles; `ready_out`=1.
- Single word 0xA5 presented at `bit_cnt`=3 → accepted that cycle; `ready_out` drops to 0 until the next `boundary`. The next word is 1,0,1,0,0,1,0,1 with `valid_out`=1, then idle 0xBC resumes.
- Back-to-back stream 0x01, 0x02, 0x03 with `valid_in` held high → three consecutive data words with no idle between them; each word is held until `ready_out`=1; `valid_out` stays 1 for 24 cycles.
- MSB_FIRST=0, idle → `data_out` repeats 0,0,1,1,1,1,0,1.
- Reset asserted at bit 4 of data word 0xA5 while `hold`=0x3C is full → next cycle shows `bit_cnt`=0 and the idle word, `ready_out`=1, `valid_out`=0. Neither 0xA5 nor 0x3C is ever transmitted.
- WIDTH=10, IDLE_WORD=10'h17C, word 10'h2AA sent at `boundary` → `word_start` every 10 cycles; bypass data bits 1,0,1,0,1,0,1,0,1,0 start on the next cycle.

Source files
------------

// File: rtl/paralelo_serie_param.sv
// Parallel-to-serial converter for the PHY transmit path.
// Accepts words through a valid/ready handshake, buffers one word in a
// holding register and shifts words out one bit per clk_8f cycle. When
// nothing is pending, the idle word is transmitted instead.
module paralelo_serie_param #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] IDLE_WORD = 8'hBC,
    parameter bit               MSB_FIRST = 1'b1
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             valid_out,
    output logic             word_start,
    output logic [WIDTH-1:0] data2send
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic             word_is_data;
    logic [WIDTH-1:0] hold;
    logic             hold_full;

    logic             boundary;
    logic             xfer;
    logic [CW-1:0]    bit_idx;

    // Output decode and handshake; the holding register frees up at the
    // last bit, so a new word can be taken there even when it is full.
    always_comb begin
        boundary   = (bit_cnt == LAST);
        ready_out  = !hold_full || boundary;
        xfer       = valid_in && ready_out;
        bit_idx    = MSB_FIRST ? (LAST - bit_cnt) : bit_cnt;
        data_out   = shreg[bit_idx];
        word_start = (bit_cnt == '0);
        valid_out  = word_is_data;
        data2send  = shreg;
    end

    // Bit counter, shift word selection at word boundaries, holding register.
    always_ff @(posedge clk_8f) begin
        if (reset) begin
            bit_cnt      <= '0;
            shreg        <= IDLE_WORD;
            word_is_data <= 1'b0;
            hold         <= '0;
            hold_full    <= 1'b0;
        end else begin
            bit_cnt <= boundary ? '0 : bit_cnt + 1'b1;
            if (boundary) begin
                if (hold_full) begin
                    // Held word goes out next; a simultaneous write refills hold.
                    shreg        <= hold;
                    word_is_data <= 1'b1;
                    if (xfer) begin
                        hold <= data_in;
                    end
                    hold_full <= xfer;
                end else if (xfer) begin
                    // Nothing waiting: the incoming word bypasses hold.
                    shreg        <= data_in;
                    word_is_data <= 1'b1;
                end else begin
                    shreg        <= IDLE_WORD;
                    word_is_data <= 1'b0;
                end
            end else if (xfer) begin
                hold      <= data_in;
                hold_full <= 1'b1;
            end
        end
    end

endmodule
